// File: rtl/password_store_pkg.sv
// Shared definitions for the passcode store: op encodings, defaults, FSM states.
package password_store_pkg;

    localparam int unsigned DEF_SLOTS   = 4;
    localparam int unsigned DEF_DIGITS  = 4;
    localparam int unsigned DEF_DIGIT_W = 4;

    // op_mode encodings driven by the lock controller
    typedef enum logic [1:0] {
        OP_STANDBY = 2'd0,
        OP_SAVE    = 2'd1,
        OP_DELETE  = 2'd2,
        OP_COMPARE = 2'd3
    } op_e;

    // Request FSM states, also visible to controller-side checkers
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/password_store_if.sv
// Controller <-> passcode store request/response bundle.
//   master: lock controller (drives op_mode, *_start, code_in)
//   slave : password_store (drives done pulses, match, error_open, busy, slots_used)
interface password_store_if #(
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4
);
    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(SLOTS + 1);

    logic [1:0]        op_mode;
    logic              save_start;
    logic              delete_start;
    logic              compare_start;
    logic [CODE_W-1:0] code_in;
    logic              saver_done;
    logic              deleter_done;
    logic              comparator_done;
    logic              match;
    logic              error_open;
    logic              busy;
    logic [CNT_W-1:0]  slots_used;

    modport master (
        output op_mode, save_start, delete_start, compare_start, code_in,
        input  saver_done, deleter_done, comparator_done, match, error_open,
               busy, slots_used
    );

    modport slave (
        input  op_mode, save_start, delete_start, compare_start, code_in,
        output saver_done, deleter_done, comparator_done, match, error_open,
               busy, slots_used
    );
endinterface

// File: rtl/password_store_code_slot_bank.sv
// Passcode storage: valid bits + code array with one indexed read port,
// one write/clear port and a registered popcount of valid slots.
//   rd_idx/rd_valid_c/rd_code_c : combinational slot read
//   wr_en/wr_set/wr_idx/wr_code : wr_set=1 writes code and sets valid,
//                                 wr_set=0 clears valid only
//   slots_used                  : count of valid slots, tracks the write
module password_store_code_slot_bank #(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned CODE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(SLOTS)-1:0]     rd_idx,
    output logic                         rd_valid_c,
    output logic [CODE_W-1:0]            rd_code_c,
    input  logic                         wr_en,
    input  logic                         wr_set,
    input  logic [$clog2(SLOTS)-1:0]     wr_idx,
    input  logic [CODE_W-1:0]            wr_code,
    output logic [$clog2(SLOTS+1)-1:0]   slots_used
);
    localparam int unsigned CNT_W = $clog2(SLOTS + 1);

    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [CODE_W-1:0] code_q [SLOTS];
    logic [CODE_W-1:0] code_d [SLOTS];
    logic [CNT_W-1:0]  used_q, used_d;

    assign rd_valid_c = valid_q[rd_idx];
    assign rd_code_c  = code_q[rd_idx];
    assign slots_used = used_q;

    // Next storage state; count derived from next valid so it moves with the write
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        used_d  = '0;
        if (wr_en) begin
            valid_d[wr_idx] = wr_set;
            if (wr_set) begin
                code_d[wr_idx] = wr_code;
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            used_d = used_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            used_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            used_q  <= used_d;
            code_q  <= code_d;
        end
    end
endmodule

// File: rtl/password_store.sv
// Passcode store responder: accepts save/delete/compare requests on rising
// start edges, scans every slot once, applies the update, pulses a done.
//   clk, reset_n : clock, async active-low reset
//   bus          : password_store_if.slave request/response bundle
module password_store
    import password_store_pkg::*;
#(
    parameter int unsigned SLOTS   = DEF_SLOTS,
    parameter int unsigned DIGITS  = DEF_DIGITS,
    parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    password_store_if.slave  bus
);
    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = $clog2(SLOTS);
    localparam int unsigned CNT_W  = $clog2(SLOTS + 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              hit_q, hit_d, free_q, free_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    logic              save_start_q, delete_start_q, compare_start_q;
    logic              saver_done_q, saver_done_d;
    logic              deleter_done_q, deleter_done_d;
    logic              comparator_done_q, comparator_done_d;
    logic              match_q, match_d, error_q, error_d, busy_q, busy_d;

    logic              save_edge, delete_edge, compare_edge;
    logic              rd_valid;
    logic [CODE_W-1:0] rd_code;
    logic              wr_en, wr_set;
    logic [IDX_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  slots_used;
    op_e               req;

    assign save_edge    = bus.save_start    & ~save_start_q;
    assign delete_edge  = bus.delete_start  & ~delete_start_q;
    assign compare_edge = bus.compare_start & ~compare_start_q;

    password_store_code_slot_bank #(.SLOTS(SLOTS), .CODE_W(CODE_W)) u_bank (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx     (idx_q),
        .rd_valid_c (rd_valid),
        .rd_code_c  (rd_code),
        .wr_en      (wr_en),
        .wr_set     (wr_set),
        .wr_idx     (wr_idx),
        .wr_code    (code_q),
        .slots_used (slots_used)
    );

    // Next-state and result logic
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        code_d            = code_q;
        idx_d             = idx_q;
        hit_d             = hit_q;
        hit_idx_d         = hit_idx_q;
        free_d            = free_q;
        free_idx_d        = free_idx_q;
        match_d           = match_q;
        error_d           = error_q;
        busy_d            = busy_q;
        saver_done_d      = 1'b0;
        deleter_done_d    = 1'b0;
        comparator_done_d = 1'b0;
        wr_en             = 1'b0;
        wr_set            = 1'b0;
        wr_idx            = '0;
        req               = OP_STANDBY;

        // busy covers the done pulse cycle, then drops
        if (saver_done_q || deleter_done_q || comparator_done_q) begin
            busy_d = 1'b0;
        end

        // Priority pick first; the winner must also match op_mode
        if (save_edge) begin
            req = OP_SAVE;
        end else if (delete_edge) begin
            req = OP_DELETE;
        end else if (compare_edge) begin
            req = OP_COMPARE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!busy_q && req != OP_STANDBY && bus.op_mode == req) begin
                    op_d    = req;
                    code_d  = bus.code_in;
                    match_d = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    free_d  = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Keep only the lowest-index hit and free slot
                if (rd_valid && rd_code == code_q && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!rd_valid && !free_q) begin
                    free_d     = 1'b1;
                    free_idx_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(SLOTS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                case (op_q)
                    OP_SAVE: begin
                        if (hit_q || !free_q) begin
                            error_d = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wr_set = 1'b1;
                            wr_idx = free_idx_q;
                        end
                    end
                    OP_DELETE: begin
                        // The last remaining code can never be deleted
                        if (!hit_q || slots_used == CNT_W'(1)) begin
                            error_d = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wr_idx = hit_idx_q;
                        end
                    end
                    OP_COMPARE: match_d = hit_q;
                    default: ;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                saver_done_d      = (op_q == OP_SAVE);
                deleter_done_d    = (op_q == OP_DELETE);
                comparator_done_d = (op_q == OP_COMPARE);
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            op_q              <= OP_STANDBY;
            code_q            <= '0;
            idx_q             <= '0;
            hit_q             <= 1'b0;
            hit_idx_q         <= '0;
            free_q            <= 1'b0;
            free_idx_q        <= '0;
            save_start_q      <= 1'b0;
            delete_start_q    <= 1'b0;
            compare_start_q   <= 1'b0;
            saver_done_q      <= 1'b0;
            deleter_done_q    <= 1'b0;
            comparator_done_q <= 1'b0;
            match_q           <= 1'b0;
            error_q           <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            code_q            <= code_d;
            idx_q             <= idx_d;
            hit_q             <= hit_d;
            hit_idx_q         <= hit_idx_d;
            free_q            <= free_d;
            free_idx_q        <= free_idx_d;
            save_start_q      <= bus.save_start;
            delete_start_q    <= bus.delete_start;
            compare_start_q   <= bus.compare_start;
            saver_done_q      <= saver_done_d;
            deleter_done_q    <= deleter_done_d;
            comparator_done_q <= comparator_done_d;
            match_q           <= match_d;
            error_q           <= error_d;
            busy_q            <= busy_d;
        end
    end

    assign bus.saver_done      = saver_done_q;
    assign bus.deleter_done    = deleter_done_q;
    assign bus.comparator_done = comparator_done_q;
    assign bus.match           = match_q;
    assign bus.error_open      = error_q;
    assign bus.busy            = busy_q;
    assign bus.slots_used      = slots_used;
endmodule

// File: tb/tb_password_store.sv
// Bench for password_store: table of requests with expected results, queued
// on issue and checked when the done pulse appears, plus corner sequences.
module tb_password_store;
    import password_store_pkg::*;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned LAT   = SLOTS + 2;

    logic clk;
    logic reset_n;

    password_store_if #(.SLOTS(SLOTS), .DIGITS(4), .DIGIT_W(4)) bus ();

    password_store #(.SLOTS(SLOTS), .DIGITS(4), .DIGIT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        s;
        logic        d;
        logic        c;
        logic [15:0] code;
        logic [2:0]  done_exp;   // {saver, deleter, comparator}
        logic        err;
        logic        match;
        logic [2:0]  slots;
    } vec_t;

    int   checks = 0;
    int   fails  = 0;
    vec_t sb[$];
    vec_t vecs[18];

    function automatic vec_t mk(input int op, input logic [15:0] code,
                                input logic err, input logic match, input int slots);
        vec_t v;
        v.mode     = 2'(op);
        v.s        = (op == 1);
        v.d        = (op == 2);
        v.c        = (op == 3);
        v.code     = code;
        v.done_exp = (op == 1) ? 3'b100 : (op == 2) ? 3'b010 : 3'b001;
        v.err      = err;
        v.match    = match;
        v.slots    = 3'(slots);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] dones();
        return {bus.saver_done, bus.deleter_done, bus.comparator_done};
    endfunction

    task automatic drop_starts();
        bus.save_start    = 1'b0;
        bus.delete_start  = 1'b0;
        bus.compare_start = 1'b0;
    endtask

    // Count done pulses over n cycles; none expected, busy must stay low
    task automatic watch_quiet(input int n, input string tag);
        int extra = 0;
        int busy_seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (dones() != 3'b000) extra++;
            if (bus.busy) busy_seen++;
        end
        chk({tag, " extra_done"}, 32'(extra), 0);
        chk({tag, " busy_seen"}, 32'(busy_seen), 0);
    endtask

    // Issue one request, wait for its done, check against the queued expectation
    task automatic run_op(input vec_t v, input int hold, input string tag);
        vec_t e;
        int   lat;
        bit   got;
        int   extra;
        sb.push_back(v);
        @(posedge clk); #1;
        bus.op_mode       = v.mode;
        bus.code_in       = v.code;
        bus.save_start    = v.s;
        bus.delete_start  = v.d;
        bus.compare_start = v.c;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            if (dones() != 3'b000) got = 1;
            else lat++;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, " done_timeout"}, 0, 1);
        end else begin
            chk({tag, " done_kind"}, 32'(dones()), 32'(e.done_exp));
            chk({tag, " latency"}, 32'(lat), 32'(LAT));
            chk({tag, " error_open"}, 32'(bus.error_open), 32'(e.err));
            chk({tag, " match"}, 32'(bus.match), 32'(e.match));
            chk({tag, " slots_used"}, 32'(bus.slots_used), 32'(e.slots));
            chk({tag, " busy_at_done"}, 32'(bus.busy), 1);
        end
        // Starts stay high past done: no new request may start
        extra = 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk({tag, " busy_after"}, 32'(bus.busy), 0);
            if (dones() != 3'b000) extra++;
        end
        chk({tag, " extra_done"}, 32'(extra), 0);
        drop_starts();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dones"}, 32'(dones()), 0);
        chk({tag, " match"}, 32'(bus.match), 0);
        chk({tag, " error_open"}, 32'(bus.error_open), 0);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " slots_used"}, 32'(bus.slots_used), 0);
    endtask

    initial begin
        // Request table, applied in order starting from an empty store
        vecs[0]  = mk(1, 16'h1234, 1'b0, 1'b0, 1);  // save to empty
        vecs[1]  = mk(3, 16'h1234, 1'b0, 1'b1, 1);  // compare hit
        vecs[2]  = mk(3, 16'h9999, 1'b0, 1'b0, 1);  // compare miss
        vecs[3]  = mk(1, 16'h1234, 1'b1, 1'b0, 1);  // duplicate save
        vecs[4]  = mk(2, 16'h1234, 1'b1, 1'b0, 1);  // delete last code
        vecs[5]  = mk(3, 16'h1234, 1'b0, 1'b1, 1);  // still stored
        vecs[6]  = mk(1, 16'h4321, 1'b0, 1'b0, 2);
        vecs[7]  = mk(2, 16'h1234, 1'b0, 1'b0, 1);  // delete ok
        vecs[8]  = mk(2, 16'h7777, 1'b1, 1'b0, 1);  // delete absent
        vecs[9]  = mk(3, 16'h1234, 1'b0, 1'b0, 1);  // gone
        vecs[10] = mk(1, 16'h1111, 1'b0, 1'b0, 2);  // reuses slot 0
        vecs[11] = mk(1, 16'h2222, 1'b0, 1'b0, 3);
        vecs[12] = mk(1, 16'h3333, 1'b0, 1'b0, 4);
        vecs[13] = mk(1, 16'h5555, 1'b1, 1'b0, 4);  // full
        vecs[14] = mk(3, 16'h3333, 1'b0, 1'b1, 4);
        vecs[15] = mk(2, 16'h1111, 1'b0, 1'b0, 3);
        vecs[16] = mk(1, 16'h5555, 1'b0, 1'b0, 4);
        vecs[17] = mk(3, 16'h5555, 1'b0, 1'b1, 4);

        reset_n     = 1'b0;
        bus.op_mode = 2'd0;
        bus.code_in = 16'h0;
        drop_starts();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i], (i == 0) ? 12 : 2, $sformatf("vec%0d", i));
        end

        // Save and delete edges together with op_mode=save: only save served (store full)
        begin
            vec_t v;
            v   = mk(1, 16'h6666, 1'b1, 1'b0, 4);
            v.d = 1'b1;
            run_op(v, 12, "save_vs_delete");
        end

        // Edge with standby op_mode is dropped
        @(posedge clk); #1;
        bus.op_mode    = 2'd0;
        bus.code_in    = 16'h8888;
        bus.save_start = 1'b1;
        watch_quiet(12, "standby_edge");
        drop_starts();
        @(posedge clk); #1;

        // Reset in the middle of SCAN aborts and clears storage
        @(posedge clk); #1;
        bus.op_mode    = 2'd1;
        bus.code_in    = 16'h7777;
        bus.save_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scan busy_before_reset", 32'(bus.busy), 1);
        drop_starts();
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_scan_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        watch_quiet(12, "after_abort");
        run_op(mk(3, 16'h3333, 1'b0, 1'b0, 0), 2, "cmp_after_abort");
        run_op(mk(1, 16'h1234, 1'b0, 1'b0, 1), 2, "save_after_abort");
        run_op(mk(3, 16'h1234, 1'b0, 1'b1, 1), 2, "cmp_slot0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
